// File: rtl/rom_dl_sdram_writer.sv
// Packs the byte-wide ROM download stream into 16-bit strobed words, queues them and
// writes each one through a req/ack toggle sdram port; also reports download status.
module rom_dl_sdram_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 23
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          port_req,
  input  logic          port_ack,
  output logic [AW-1:0] port_a,
  output logic [1:0]    port_ds,
  output logic          port_we,
  output logic [15:0]   port_d,
  output logic          rom_loaded,
  output logic          busy,
  output logic          overflow
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FullCount = (PW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [0:0]    state_q;
  logic          wr_q, dl_q, got_byte_q;

  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_a_q, pend_a_d;
  logic [1:0]    pend_ds_q, pend_ds_d;
  logic [15:0]   pend_d_q, pend_d_d;

  logic [AW-1:0] fifo_a  [FIFO_DEPTH];
  logic [1:0]    fifo_ds [FIFO_DEPTH];
  logic [15:0]   fifo_d  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;

  logic          capture, dl_fall, dl_rise;
  logic [AW-1:0] cap_wa;
  logic          cap_odd;
  logic          push, push_ok, pop, fifo_empty, fifo_full, load_done;
  logic [AW-1:0] push_a;
  logic [1:0]    push_ds;
  logic [15:0]   push_d;
  logic          unused_addr_hi;

  // Address bits above the word address range are deliberately ignored.
  assign unused_addr_hi = ^(ioctl_addr >> (AW + 1));

  assign capture    = ioctl_download & ioctl_wr & ~wr_q;
  assign dl_fall    = dl_q & ~ioctl_download;
  assign dl_rise    = ~dl_q & ioctl_download;
  assign cap_wa     = ioctl_addr[AW:1];
  assign cap_odd    = ioctl_addr[0];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FullCount);
  assign pop        = (state_q == StWait) && (port_ack == port_req);
  assign push_ok    = push && (!fifo_full || pop);
  assign load_done  = got_byte_q && !ioctl_download && !pend_valid_q && fifo_empty &&
                      (state_q == StIdle);
  assign busy       = ioctl_download | pend_valid_q | ~fifo_empty | (state_q == StWait);

  // Pending-slot merge: an odd byte completes a pending even byte of the same word,
  // anything else evicts the pending entry and takes its place.
  always_comb begin
    push         = 1'b0;
    push_a       = pend_a_q;
    push_ds      = pend_ds_q;
    push_d       = pend_d_q;
    pend_valid_d = pend_valid_q;
    pend_a_d     = pend_a_q;
    pend_ds_d    = pend_ds_q;
    pend_d_d     = pend_d_q;
    if (capture) begin
      if (pend_valid_q && (pend_ds_q == 2'b01) && cap_odd && (cap_wa == pend_a_q)) begin
        push         = 1'b1;
        push_ds      = 2'b11;
        push_d       = {ioctl_dout, pend_d_q[7:0]};
        pend_valid_d = 1'b0;
      end else begin
        push         = pend_valid_q;
        pend_valid_d = 1'b1;
        pend_a_d     = cap_wa;
        pend_ds_d    = cap_odd ? 2'b10 : 2'b01;
        pend_d_d     = cap_odd ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
      end
    end else if (dl_fall && pend_valid_q) begin
      push         = 1'b1;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      fifo_a[wr_ptr_q]  <= push_a;
      fifo_ds[wr_ptr_q] <= push_ds;
      fifo_d[wr_ptr_q]  <= push_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      port_req     <= port_ack;
      port_a       <= '0;
      port_ds      <= '0;
      port_d       <= '0;
      port_we      <= 1'b0;
      rom_loaded   <= 1'b0;
      overflow     <= 1'b0;
      state_q      <= StIdle;
      wr_q         <= 1'b0;
      dl_q         <= 1'b0;
      got_byte_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_a_q     <= '0;
      pend_ds_q    <= '0;
      pend_d_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      wr_q         <= ioctl_wr;
      dl_q         <= ioctl_download;
      pend_valid_q <= pend_valid_d;
      pend_a_q     <= pend_a_d;
      pend_ds_q    <= pend_ds_d;
      pend_d_q     <= pend_d_d;

      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // The head stays queued while in flight; it is popped only on acknowledge.
      if (state_q == StIdle) begin
        if (!fifo_empty) begin
          port_a   <= fifo_a[rd_ptr_q];
          port_ds  <= fifo_ds[rd_ptr_q];
          port_d   <= fifo_d[rd_ptr_q];
          port_we  <= 1'b1;
          port_req <= ~port_req;
          state_q  <= StWait;
        end
      end else if (pop) begin
        port_we <= 1'b0;
        state_q <= StIdle;
      end

      if (dl_rise) begin
        rom_loaded <= 1'b0;
        got_byte_q <= 1'b0;
      end
      if (capture) begin
        got_byte_q <= 1'b1;
      end else if (load_done) begin
        rom_loaded <= 1'b1;
        got_byte_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_dl_sdram_writer.sv
// Randomized and directed bench for rom_dl_sdram_writer; a byte-level packing model
// predicts the ordered sdram writes and the status outputs.
module tb_rom_dl_sdram_writer;

  localparam int FIFO_DEPTH = 4;
  localparam int AW         = 23;

  logic          clk_sys = 1'b0;
  logic          reset_n, ioctl_download, ioctl_wr, port_ack;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          port_req, port_we, rom_loaded, busy, overflow;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic [15:0]   port_d;

  rom_dl_sdram_writer #(.FIFO_DEPTH(FIFO_DEPTH), .AW(AW)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .port_req       (port_req),
    .port_ack       (port_ack),
    .port_a         (port_a),
    .port_ds        (port_ds),
    .port_we        (port_we),
    .port_d         (port_d),
    .rom_loaded     (rom_loaded),
    .busy           (busy),
    .overflow       (overflow)
  );

  initial forever #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [1:0]    ds;
    logic [15:0]   d;
  } word_t;

  word_t exp_q[$];
  word_t log_q[$];
  word_t cur_w;

  // Model of the byte packer
  bit            m_pv;
  logic [AW-1:0] m_a;
  logic [1:0]    m_ds;
  logic [15:0]   m_d;
  bit            m_overflow;
  bit            ack_held;
  int            held_accepted;
  int            unacked;

  int  n_tests, n_fail, req_count, lat;
  bit  hold;
  logic prev_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ds_mask(input logic [1:0] ds);
    return {{8{ds[1]}}, {8{ds[0]}}};
  endfunction

  // With acks withheld nothing leaves the queue, so only FIFO_DEPTH words fit
  // (the in-flight head still occupies its entry).
  task automatic push_word(input word_t w);
    log_q.push_back(w);
    if (ack_held && held_accepted >= FIFO_DEPTH) begin
      m_overflow = 1'b1;
    end else begin
      if (ack_held) held_accepted++;
      exp_q.push_back(w);
      unacked++;
    end
  endtask

  task automatic model_byte(input logic [24:0] addr, input logic [7:0] data);
    logic [AW-1:0] wa;
    word_t w;
    wa = addr[AW:1];
    if (m_pv && m_ds == 2'b01 && addr[0] && wa == m_a) begin
      w.a = m_a; w.ds = 2'b11; w.d = {data, m_d[7:0]};
      push_word(w);
      m_pv = 1'b0;
    end else begin
      if (m_pv) begin
        w.a = m_a; w.ds = m_ds; w.d = m_d;
        push_word(w);
      end
      m_pv = 1'b1;
      m_a  = wa;
      m_ds = addr[0] ? 2'b10 : 2'b01;
      m_d  = addr[0] ? {data, 8'h00} : {8'h00, data};
    end
  endtask

  task automatic model_flush();
    word_t w;
    if (m_pv) begin
      w.a = m_a; w.ds = m_ds; w.d = m_d;
      push_word(w);
      m_pv = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pv = 1'b0; m_overflow = 1'b0; unacked = 0; held_accepted = 0; ack_held = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data,
                           input int hi, input int gap);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    if (ioctl_download) model_byte(addr, data);
    repeat (hi) tick();
    ioctl_wr = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic end_download();
    ioctl_download = 1'b0;
    model_flush();
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (i < 3000 && (exp_q.size() != 0 || unacked != 0)) begin
      tick();
      i++;
    end
    if (i >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d writes still pending, expected 0", name, exp_q.size());
    end
    repeat (4) tick();
  endtask

  // sdram stand-in: acknowledges an outstanding request after lat cycles
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      tick();
      if (!reset_n || port_req === port_ack || hold) begin
        cnt = 0;
      end else if (cnt >= lat) begin
        port_ack = port_req;
        unacked--;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  // Compare process: every new request, every waiting cycle, and busy every cycle
  initial begin
    prev_req = 1'b1;
    forever begin
      @(negedge clk_sys);
      if (reset_n === 1'b1) begin
        if (port_req !== prev_req) begin
          req_count++;
          check("req_we", port_we, 1);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_req: got a=0x%0h ds=%b d=0x%0h, expected no request",
                     port_a, port_ds, port_d);
          end else begin
            cur_w = exp_q.pop_front();
            check("req_a", port_a, cur_w.a);
            check("req_ds", port_ds, cur_w.ds);
            check("req_d", port_d & ds_mask(cur_w.ds), cur_w.d & ds_mask(cur_w.ds));
          end
        end else if (port_req !== port_ack) begin
          check("hold_a", port_a, cur_w.a);
          check("hold_ds", port_ds, cur_w.ds);
          check("hold_d", port_d & ds_mask(cur_w.ds), cur_w.d & ds_mask(cur_w.ds));
          check("hold_we", port_we, 1);
        end
        if (ioctl_download || m_pv || unacked > 0) check("busy_work", busy, 1);
      end
      prev_req = port_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [24:0] addr;
    n_tests = 0; n_fail = 0; req_count = 0; lat = 2; hold = 1'b0;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; port_ack = 1'b1;
    model_reset();

    // Reset state with port_ack high
    repeat (3) tick();
    check("rst_req", port_req, 1);
    check("rst_we", port_we, 0);
    check("rst_ds", port_ds, 0);
    check("rst_a", port_a, 0);
    check("rst_loaded", rom_loaded, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    repeat (10) tick();
    check("idle_no_req", req_count, 0);
    check("idle_req_level", port_req, 1);

    // Two full words
    lat = 3; log_q.delete(); base = req_count;
    ioctl_download = 1'b1; tick();
    send_byte(25'd0, 8'h11, 1, 3);
    send_byte(25'd1, 8'h22, 1, 3);
    send_byte(25'd2, 8'h33, 1, 3);
    send_byte(25'd3, 8'h44, 1, 3);
    end_download();
    wait_idle("full_words");
    check("fw_count", req_count - base, 2);
    check("fw_log_n", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("fw0_a", log_q[0].a, 0);
      check("fw0_ds", log_q[0].ds, 2'b11);
      check("fw0_d", log_q[0].d, 16'h2211);
      check("fw1_a", log_q[1].a, 1);
      check("fw1_ds", log_q[1].ds, 2'b11);
      check("fw1_d", log_q[1].d, 16'h4433);
    end
    check("fw_loaded", rom_loaded, 1);
    check("fw_busy", busy, 0);

    // Isolated odd then even byte
    lat = 1; log_q.delete(); base = req_count;
    ioctl_download = 1'b1; tick(); tick();
    check("dl_clears_loaded", rom_loaded, 0);
    send_byte(25'd5, 8'hAA, 1, 3);
    send_byte(25'd8, 8'hBB, 1, 3);
    end_download();
    wait_idle("partial");
    check("pt_count", req_count - base, 2);
    check("pt_log_n", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("pt0_a", log_q[0].a, 2);
      check("pt0_ds", log_q[0].ds, 2'b10);
      check("pt0_hi", log_q[0].d[15:8], 8'hAA);
      check("pt1_a", log_q[1].a, 4);
      check("pt1_ds", log_q[1].ds, 2'b01);
      check("pt1_lo", log_q[1].d[7:0], 8'hBB);
    end
    check("pt_loaded", rom_loaded, 1);

    // Long write strobe, then strobes outside a download
    base = req_count;
    ioctl_download = 1'b1; tick();
    send_byte(25'h100, 8'h5A, 5, 3);
    end_download();
    wait_idle("long_wr");
    check("lw_count", req_count - base, 1);
    base = req_count;
    for (int i = 0; i < 3; i++) send_byte(25'($urandom), 8'($urandom), 1, 2);
    repeat (20) tick();
    check("nodl_count", req_count - base, 0);
    check("nodl_loaded", rom_loaded, 1);

    // Overflow with acks withheld
    lat = 2; hold = 1'b1; ack_held = 1'b1; held_accepted = 0; base = req_count;
    ioctl_download = 1'b1; tick();
    for (int w = 0; w < FIFO_DEPTH + 2; w++) begin
      send_byte(25'(32'h40 + 2 * w), 8'(w * 16 + 1), 1, 1);
      send_byte(25'(32'h41 + 2 * w), 8'(w * 16 + 2), 1, 1);
    end
    end_download();
    repeat (5) tick();
    check("ovf_flag", overflow, m_overflow);
    check("ovf_busy", busy, 1);
    check("ovf_one_inflight", req_count - base, 1);
    hold = 1'b0; ack_held = 1'b0;
    wait_idle("overflow");
    check("ovf_written", req_count - base, FIFO_DEPTH);
    check("ovf_sticky", overflow, 1);
    check("ovf_busy_end", busy, 0);
    check("ovf_loaded", rom_loaded, 1);

    // Reset while a write is waiting for its ack
    hold = 1'b1; lat = 1;
    ioctl_download = 1'b1; tick();
    send_byte(25'h200, 8'hC1, 1, 2);
    send_byte(25'h201, 8'hC2, 1, 2);
    end_download();
    repeat (4) tick();
    check("wait_lag", port_req != port_ack, 1);
    reset_n = 1'b0;
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1; hold = 1'b0;
    tick();
    check("rr_req_eq_ack", port_req, port_ack);
    check("rr_we", port_we, 0);
    check("rr_busy", busy, 0);
    check("rr_ovf", overflow, 0);
    check("rr_loaded", rom_loaded, 0);
    base = req_count;
    repeat (10) tick();
    check("rr_no_reissue", req_count - base, 0);
    ioctl_download = 1'b1; tick();
    for (int i = 0; i < 6; i++) send_byte(25'(32'h300 + i), 8'($urandom), 1, 3);
    end_download();
    wait_idle("after_reset");
    check("rr_count", req_count - base, 3);
    check("rr_done_loaded", rom_loaded, 1);

    // Randomized downloads
    for (int t = 0; t < 6; t++) begin
      lat = $urandom_range(0, 3);
      ioctl_download = 1'b1; tick();
      addr = 25'($urandom);
      for (int i = $urandom_range(8, 30); i > 0; i--) begin
        send_byte(addr, 8'($urandom), $urandom_range(1, 3), $urandom_range(6, 9));
        if ($urandom_range(0, 9) < 7) addr = addr + 25'd1;
        else addr = 25'($urandom);
      end
      end_download();
      wait_idle("random");
      check("rnd_loaded", rom_loaded, 1);
      check("rnd_busy", busy, 0);
      check("rnd_ovf", overflow, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
